// File: rtl/carrier_freq_meter.sv
// Carrier frequency meter: slices 8-bit samples with hysteresis and reports the
// number of clocks spanned by PERIODS rising crossings of the sliced signal.
module carrier_freq_meter #(
    parameter int PERIODS     = 256,
    parameter int COUNT_WIDTH = 24,
    parameter int HYST        = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sample_valid,
    input  logic [7:0]             sample,
    input  logic [7:0]             midpoint,
    output logic [COUNT_WIDTH-1:0] period_sum,
    output logic                   result_valid,
    output logic                   timeout,
    output logic                   locked
);

    localparam int EW = (PERIODS > 1) ? $clog2(PERIODS + 1) : 1;
    localparam logic [EW-1:0] LAST_EDGE = EW'(PERIODS - 1);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t                 state;
    logic                   level;
    logic                   level_q;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [EW-1:0]          edges;

    logic [8:0] up_sum;
    logic [7:0] upper;
    logic [7:0] lower;
    logic       rise;

    // Thresholds saturate at the ends of the 8-bit range.
    always_comb begin
        up_sum = {1'b0, midpoint} + 9'(HYST);
        upper  = up_sum[8] ? 8'hFF : up_sum[7:0];
        lower  = (midpoint >= 8'(HYST)) ? (midpoint - 8'(HYST)) : '0;
        rise   = level & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            level        <= 1'b0;
            level_q      <= 1'b0;
            cnt          <= '0;
            edges        <= '0;
            period_sum   <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            locked       <= 1'b0;
        end else begin
            level_q      <= level;
            result_valid <= 1'b0;
            timeout      <= 1'b0;

            // HIGH test first so it wins when upper == lower.
            if (sample_valid) begin
                if (sample >= upper) begin
                    level <= 1'b1;
                end else if (sample <= lower) begin
                    level <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    cnt   <= '0;
                    edges <= '0;
                    if (rise) begin
                        state  <= MEASURE;
                        cnt    <= COUNT_WIDTH'(1);
                        locked <= 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        if (edges == LAST_EDGE) begin
                            period_sum   <= cnt;
                            result_valid <= 1'b1;
                            cnt          <= COUNT_WIDTH'(1);
                            edges        <= '0;
                        end else begin
                            edges <= edges + EW'(1);
                            cnt   <= cnt + COUNT_WIDTH'(1);
                        end
                    end else if (cnt == '1) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                        cnt     <= '0;
                        edges   <= '0;
                        locked  <= 1'b0;
                    end else begin
                        cnt <= cnt + COUNT_WIDTH'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_carrier_freq_meter.sv
// Directed bench for carrier_freq_meter: PERIODS=4, COUNT_WIDTH=8, with a HYST=4
// instance and a HYST=2 instance sharing the same stimulus.
module tb_carrier_freq_meter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample = '0;
    logic [7:0] midpoint = 8'd100;

    logic [7:0] period_sum, period_sum2;
    logic       result_valid, result_valid2;
    logic       timeout, timeout2;
    logic       locked, locked2;

    int total = 0;
    int bad = 0;

    int nres, first_res, last_sum, bad_sum, nres2, last_sum2;
    int ntmo, first_tmo, unlock, both;
    bit lk [0:399];
    int ps_hist [0:399];

    always #5 clk = ~clk;

    carrier_freq_meter #(.PERIODS(4), .COUNT_WIDTH(8), .HYST(4)) dut (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .midpoint(midpoint), .period_sum(period_sum), .result_valid(result_valid),
        .timeout(timeout), .locked(locked)
    );

    carrier_freq_meter #(.PERIODS(4), .COUNT_WIDTH(8), .HYST(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
        .midpoint(midpoint), .period_sum(period_sum2), .result_valid(result_valid2),
        .timeout(timeout2), .locked(locked2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sample = '0;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // kind 0: square lo/hi; kind 1: sawtooth 97..103; kind 2: square for 50 clocks then lo.
    // lock_from >= 0: locked required from that cycle on; -1: never locked; -2: unchecked.
    task automatic run(input int n, input int kind, input int period, input logic [7:0] hi,
                       input logic [7:0] lo, input bit alt, input int exp_sum, input int lock_from);
        nres = 0; first_res = -1; last_sum = -1; bad_sum = 0; nres2 = 0; last_sum2 = -1;
        ntmo = 0; first_tmo = -1; unlock = 0; both = 0;
        for (int k = 0; k < n; k++) begin
            case (kind)
                0: sample = ((k % period) < period / 2) ? lo : hi;
                1: sample = 8'(97 + (k % 7));
                default: sample = (k < 50 && (k % period) >= period / 2) ? hi : lo;
            endcase
            sample_valid = alt ? (k % 2 == 0) : 1'b1;
            @(posedge clk);
            #1;
            lk[k] = locked;
            ps_hist[k] = int'(period_sum);
            if (result_valid) begin
                nres++;
                if (first_res < 0) first_res = k;
                last_sum = int'(period_sum);
                if (int'(period_sum) != exp_sum) bad_sum++;
            end
            if (result_valid2) begin
                nres2++;
                last_sum2 = int'(period_sum2);
            end
            if (timeout) begin
                ntmo++;
                if (first_tmo < 0) first_tmo = k;
            end
            if (lock_from >= 0 && k >= lock_from && !locked) unlock++;
            if (lock_from == -1 && locked) unlock++;
            if (result_valid && timeout) both++;
        end
    endtask

    initial begin
        // Reset state
        midpoint = 8'd100;
        do_reset();
        chk("rst_period_sum", 32'(period_sum), 0);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_locked", 32'(locked), 0);

        // Square 0/200, period 10: first result after 5 rises, then every 40 clocks
        run(130, 0, 10, 8'd200, 8'd0, 1'b0, 40, 6);
        chk("sq_nres", nres, 3);
        chk("sq_first_at", first_res, 46);
        chk("sq_sum", last_sum, 40);
        chk("sq_bad_sums", bad_sum, 0);
        chk("sq_locked", unlock, 0);
        chk("sq_no_tmo", ntmo, 0);
        chk("sq_rv_tmo_excl", both, 0);

        // Sawtooth 97..103: HYST=4 never toggles, HYST=2 measures 4*7 clocks
        do_reset();
        run(100, 1, 7, 8'd0, 8'd0, 1'b0, 0, -1);
        chk("saw_h4_nres", nres, 0);
        chk("saw_h4_unlocked", unlock, 0);
        chk("saw_h2_nres", nres2, 3);
        chk("saw_h2_sum", last_sum2, 28);

        // Alternating sample_valid, period 20
        do_reset();
        run(200, 0, 20, 8'd200, 8'd0, 1'b1, 80, 11);
        chk("alt_nres", nres, 2);
        chk("alt_first_at", first_res, 91);
        chk("alt_sum", last_sum, 80);
        chk("alt_locked", unlock, 0);

        // Window overflow: last rise restarts window at 46, counter saturates 255 clocks later
        do_reset();
        run(320, 2, 10, 8'd200, 8'd0, 1'b0, 40, -2);
        chk("tmo_nres", nres, 1);
        chk("tmo_count", ntmo, 1);
        chk("tmo_at", first_tmo, 301);
        chk("tmo_locked_before", 32'(lk[300]), 1);
        chk("tmo_locked_at", 32'(lk[301]), 0);
        chk("tmo_sum_held", ps_hist[301], 40);
        chk("tmo_rv_tmo_excl", both, 0);

        // Upper threshold saturation
        midpoint = 8'd254;
        do_reset();
        run(90, 0, 10, 8'd255, 8'd0, 1'b0, 40, 6);
        chk("sat_hi_first_at", first_res, 46);
        chk("sat_hi_sum", last_sum, 40);

        // Lower threshold saturation
        midpoint = 8'd1;
        do_reset();
        run(90, 0, 10, 8'd200, 8'd0, 1'b0, 40, 6);
        chk("sat_lo_first_at", first_res, 46);
        chk("sat_lo_sum", last_sum, 40);

        // Reset mid-window, then a fresh measurement
        midpoint = 8'd100;
        do_reset();
        run(60, 0, 10, 8'd200, 8'd0, 1'b0, 40, 6);
        chk("mid_pre_locked", 32'(locked), 1);
        chk("mid_pre_sum", 32'(period_sum), 40);
        do_reset();
        chk("mid_rst_sum", 32'(period_sum), 0);
        chk("mid_rst_locked", 32'(locked), 0);
        chk("mid_rst_rv", 32'(result_valid), 0);
        chk("mid_rst_tmo", 32'(timeout), 0);
        run(90, 0, 10, 8'd200, 8'd0, 1'b0, 40, 6);
        chk("mid_post_first_at", first_res, 46);
        chk("mid_post_sum", last_sum, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
